// File: rtl/mmio_pkg.sv
// Shared register map and status layout for the MMIO responder.
// No logic beyond a combinational helper; no latency or backpressure of its own.
package mmio_pkg;

  localparam logic [2:0] SEL_DATA = 3'd0;
  localparam logic [2:0] SEL_STAT = 3'd1;
  localparam logic [2:0] SEL_HALT = 3'd4;
  localparam logic [2:0] SEL_SNAP = 3'd7;

  localparam int STAT_RX_NE   = 0;
  localparam int STAT_TX_FULL = 1;

  function automatic logic [7:0] status_byte(input logic rx_ne, input logic tx_full);
    logic [7:0] s;
    s               = 8'h00;
    s[STAT_RX_NE]   = rx_ne;
    s[STAT_TX_FULL] = tx_full;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, 2**AW entries; head visible combinationally, push/pop take effect on the clock edge.
// Push when full is dropped (even with a simultaneous pop); pop when empty is a no-op.
module byte_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_responder.sv
// CPU byte-MMIO bridge to TX/RX byte streams plus halt/exit-code latch; reads return io_dout one cycle later.
// Streams use valid/ready and ignore rdy_in; optional MMIO_CYCLE_COUNTER_EN adds a snapshot-able 32-bit cycle counter.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       io_en,
  input  logic [2:0] io_sel,
  input  logic       io_wr,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       halt,
  output logic [7:0] exit_code
);

  logic       acc, rd_acc, wr_acc;
  logic       tx_empty, tx_full;
  logic       rx_empty, rx_full;
  logic [7:0] rx_head;
  logic [7:0] rd_data;

  // The reset cycle never counts as a bus access.
  assign acc      = io_en && rdy_in && !rst_in;
  assign rd_acc   = acc && !io_wr;
  assign wr_acc   = acc && io_wr;
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (wr_acc && (io_sel == SEL_DATA)),
    .push_data (io_din),
    .pop       (tx_valid && tx_ready),
    .head      (tx_data),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (rx_valid && rx_ready),
    .push_data (rx_data),
    .pop       (rd_acc && (io_sel == SEL_DATA)),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;
  logic [31:0] snap;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt <= '0;
      snap      <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (wr_acc && (io_sel == SEL_SNAP)) snap <= cycle_cnt;
    end
  end
`endif

  always_comb begin
    rd_data = 8'h00;
    case (io_sel)
      SEL_DATA: rd_data = rx_empty ? 8'h00 : rx_head;
      SEL_STAT: rd_data = status_byte(!rx_empty, tx_full);
`ifdef MMIO_CYCLE_COUNTER_EN
      SEL_HALT: rd_data = snap[7:0];
      3'd5:     rd_data = snap[15:8];
      3'd6:     rd_data = snap[23:16];
      SEL_SNAP: rd_data = snap[31:24];
`endif
      default:  rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      io_dout   <= 8'h00;
      halt      <= 1'b0;
      exit_code <= 8'h00;
    end else begin
      if (rd_acc) io_dout <= rd_data;
      // Only the first halt write lands; exit_code is frozen afterwards.
      if (wr_acc && (io_sel == SEL_HALT) && !halt) begin
        halt      <= 1'b1;
        exit_code <= io_din;
      end
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Randomised + directed bench for mmio_responder with a queue-based reference model and decoupled scoreboard.
module tb_mmio_responder;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       rdy_in = 1'b0;
  logic       io_en = 1'b0;
  logic [2:0] io_sel = 3'd0;
  logic       io_wr = 1'b0;
  logic [7:0] io_din = 8'h00;
  logic [7:0] io_dout;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       halt;
  logic [7:0] exit_code;

  mmio_responder #(.FIFO_AW(AW)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .io_en     (io_en),
    .io_sel    (io_sel),
    .io_wr     (io_wr),
    .io_din    (io_din),
    .io_dout   (io_dout),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .halt      (halt),
    .exit_code (exit_code)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as queues, plus expected-output queues for the monitor.
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  rd_exp[$];
  logic [7:0]  m_dout = 8'h00;
  logic [7:0]  m_exit = 8'h00;
  bit          m_halt = 1'b0;
  logic [31:0] m_cnt  = '0;
  logic [31:0] m_snap = '0;
  bit          m_ok   = 1'b0;
  bit          g_txr  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic state_chk();
    if (m_ok) begin
      chk("tx_valid", tx_valid, tx_q.size() != 0);
      if (tx_q.size() != 0) chk("tx_data_head", tx_data, tx_q[0]);
      chk("rx_ready", rx_ready, rx_q.size() < DEPTH);
      chk("halt", halt, m_halt);
      chk("exit_code", exit_code, m_exit);
      chk("io_dout_hold", io_dout, m_dout);
    end
  endtask

  // One clock: check settled outputs, drive inputs for the next edge, advance the model across that edge.
  task automatic cyc(input bit rst, input bit rdy, input bit en, input bit wr,
                     input logic [2:0] sel, input logic [7:0] din,
                     input bit txr, input bit rxv, input logic [7:0] rxd);
    int tx_n, rx_n;
    bit acc;
    logic [7:0] rv;
    @(posedge clk_in);
    #2;
    state_chk();
    rst_in = rst; rdy_in = rdy; io_en = en; io_wr = wr; io_sel = sel; io_din = din;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    if (rst) begin
      tx_q.delete(); rx_q.delete();
      m_dout = 8'h00; m_halt = 1'b0; m_exit = 8'h00; m_cnt = '0; m_snap = '0; m_ok = 1'b1;
    end else begin
      tx_n = tx_q.size();
      rx_n = rx_q.size();
      acc  = en && rdy;
      rv   = 8'h00;
      if (acc && !wr) begin
        if (sel == 3'd0) rv = (rx_n != 0) ? rx_q[0] : 8'h00;
        else if (sel == 3'd1) rv = {6'b0, tx_n == DEPTH, rx_n != 0};
`ifdef MMIO_CYCLE_COUNTER_EN
        else if (sel >= 3'd4) rv = 8'(m_snap >> (8 * (int'(sel) - 4)));
`endif
      end
      if (txr && tx_n > 0) tx_exp.push_back(tx_q.pop_front());
      if (acc && wr && sel == 3'd0 && tx_n < DEPTH) tx_q.push_back(din);
      if (acc && !wr && sel == 3'd0 && rx_n > 0) void'(rx_q.pop_front());
      if (rxv && rx_n < DEPTH) rx_q.push_back(rxd);
      if (acc && !wr) begin
        rd_exp.push_back(rv);
        m_dout = rv;
      end
      if (acc && wr && sel == 3'd4 && !m_halt) begin
        m_halt = 1'b1;
        m_exit = din;
      end
`ifdef MMIO_CYCLE_COUNTER_EN
      if (acc && wr && sel == 3'd7) m_snap = m_cnt;
`endif
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 1, 0, 0, 3'd0, 8'h00, g_txr, 0, 8'h00);
  endtask
  task automatic bw(input logic [2:0] sel, input logic [7:0] d);
    cyc(0, 1, 1, 1, sel, d, g_txr, 0, 8'h00);
  endtask
  task automatic br(input logic [2:0] sel);
    cyc(0, 1, 1, 0, sel, 8'h00, g_txr, 0, 8'h00);
  endtask
  task automatic rst_c();
    cyc(1, 0, 0, 0, 3'd0, 8'h00, 0, 0, 8'h00);
  endtask

  // Monitor: inputs are stable at the falling edge; transfers happen on the following rising edge.
  initial begin
    bit rd_pend;
    forever begin
      @(negedge clk_in);
      rd_pend = !rst_in && io_en && rdy_in && !io_wr;
      if (!rst_in && tx_valid && tx_ready) begin
        chk("tx_pop_expected", tx_exp.size() != 0, 1);
        if (tx_exp.size() != 0) chk("tx_stream_byte", tx_data, tx_exp.pop_front());
      end
      if (rd_pend) begin
        @(posedge clk_in);
        #1;
        chk("rd_expected", rd_exp.size() != 0, 1);
        if (rd_exp.size() != 0) chk("io_dout_read", io_dout, rd_exp.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst_c();
    rst_c();
    idle(1);
    chk("reset_io_dout", io_dout, 8'h00);
    chk("reset_rx_ready", rx_ready, 1);
    chk("reset_tx_valid", tx_valid, 0);

    // Two bytes out the TX stream, in order, then tx_valid drops.
    g_txr = 1'b1;
    bw(3'd0, 8'h41);
    bw(3'd0, 8'h42);
    idle(4);
    chk("tx_drained", tx_valid, 0);

    // Overfill TX: 17th byte dropped, status shows full only.
    g_txr = 1'b0;
    for (int i = 0; i < 17; i++) bw(3'd0, 8'(8'h80 + i));
    br(3'd1);
    idle(1);
    chk("stat_tx_full", io_dout, 8'h02);
    g_txr = 1'b1;
    idle(20);

    // RX byte read once, then empty read returns zero.
    cyc(0, 1, 0, 0, 3'd0, 8'h00, g_txr, 1, 8'h55);
    br(3'd0);
    idle(1);
    chk("rx_read_55", io_dout, 8'h55);
    br(3'd0);
    idle(1);
    chk("rx_read_empty", io_dout, 8'h00);

    // Halt is sticky and the first exit code wins.
    bw(3'd4, 8'h07);
    idle(1);
    chk("halt_set", halt, 1);
    chk("exit_first", exit_code, 8'h07);
    bw(3'd4, 8'h09);
    idle(1);
    chk("exit_kept", exit_code, 8'h07);

    // rdy_in low blocks the bus; reset mid-stream empties everything.
    g_txr = 1'b0;
    cyc(0, 0, 1, 1, 3'd0, 8'hAA, 0, 0, 8'h00);
    idle(1);
    chk("rdy_low_no_push", tx_valid, 0);
    bw(3'd0, 8'h01);
    bw(3'd0, 8'h02);
    bw(3'd0, 8'h03);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 3'd0, 8'h00, 1'b1, 1'b1, 8'(i));
    rst_c();
    idle(1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_halt", halt, 0);

`ifdef MMIO_CYCLE_COUNTER_EN
    rst_c();
    idle(100);
    bw(3'd7, 8'h00);
    br(3'd4);
    idle(1);
    chk("snap_b0", io_dout, 8'h64);
    br(3'd5);
    idle(1);
    chk("snap_b1", io_dout, 8'h00);
    br(3'd6);
    br(3'd7);
    idle(1);
    chk("snap_b3", io_dout, 8'h00);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
          $urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1), 8'($urandom));
    end
    g_txr = 1'b1;
    idle(20);
    @(negedge clk_in);
    @(posedge clk_in);
    #2;
    chk("tx_exp_left", tx_exp.size(), 0);
    chk("rd_exp_left", rd_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning log2 of each FIFO depth (16 entries).
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port rdy_in, input, 1; bus accesses are ignored while low.
REQ-005 SHALL have port io_en, input, 1; CPU byte access targets the IO region this cycle.
REQ-006 SHALL have port io_sel, input, 3; register select, taken from address bits [2:0].
REQ-007 SHALL have port io_wr, input, 1; 1 = write, 0 = read.
REQ-008 SHALL have port io_din, input, 8; write data from the CPU.
REQ-009 SHALL have port io_dout, output, 8; registered read data to the CPU.
REQ-010 SHALL have ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1); together they form the outbound byte stream.
REQ-011 SHALL have ports rx_data (input, 8), rx_valid (input, 1) and rx_ready (output, 1); together they form the inbound byte stream.
REQ-012 SHALL have ports halt (output, 1) and exit_code (output, 8); these form the program-end indication.

Function
REQ-013 SHALL treat an access as occurring only in a cycle with io_en=1 and rdy_in=1.
REQ-014 SHALL push io_din into the TX FIFO on a write to sel 0; if the FIFO is full, the byte is dropped, even when a pop occurs in the same cycle.
REQ-015 SHALL pop the RX FIFO on a read of sel 0 and return the head byte; if the FIFO is empty, it returns 0x00 and no state changes.
REQ-016 SHALL return status on a read of sel 1: bit0 = RX FIFO non-empty, bit1 = TX FIFO full, bits 7:2 = 0; status reflects state in the access cycle.
REQ-017 SHALL, on a write to sel 4, set halt (sticky until reset) and latch io_din into exit_code; later sel 4 writes are ignored.
REQ-018 SHALL return 0x00 on reads of unmapped sel values, and SHALL ignore writes to them.
REQ-019 SHALL update io_dout exactly one cycle after a read access, and SHALL hold it until the next read access.
REQ-020 SHALL drive tx_valid = TX FIFO non-empty and tx_data = TX head; a pop occurs on tx_valid and tx_ready, and tx_valid/tx_data stay stable until that pop.
REQ-021 SHALL drive rx_ready = RX FIFO not full; a push occurs on rx_valid and rx_ready.
REQ-022 SHALL allow an RX push and a CPU pop in the same cycle; on empty, the pop returns 0x00 and the push is stored.
REQ-023 SHALL allow a TX CPU push and a stream pop in the same cycle when the FIFO is not full, leaving the count unchanged.
REQ-024 SHALL keep FIFO pointers FIFO_AW bits wide with natural wrap, and keep counts FIFO_AW+1 bits wide.
REQ-025 SHALL leave stream-side transfers unaffected by rdy_in.

Reset
REQ-026 SHALL, on rst_in, set io_dout=0x00, tx_valid=0, rx_ready=1, halt=0, exit_code=0x00, and both FIFOs empty.
REQ-027 SHALL, on reset mid-transfer, discard all FIFO contents and make no bus access in the reset cycle.

Configuration
REQ-028 SHALL, when macro MMIO_CYCLE_COUNTER_EN is defined:
- keep a 32-bit cycle counter, cleared by reset, incrementing every cycle and wrapping at 2^32;
- on a write to sel 7, snapshot the counter;
- on reads of sel 4/5/6/7, return snapshot bytes 0/1/2/3.
REQ-029 SHALL, when MMIO_CYCLE_COUNTER_EN is undefined, contain no counter, treat sel 7 writes as ignored, and return 0x00 on reads of sel 4..7.

Structure
REQ-030 SHALL take the sel constants (SEL_DATA=0, SEL_STAT=1, SEL_HALT=4, SEL_SNAP=7) and the status bit positions from shared package mmio_pkg.
REQ-031 SHALL instantiate sub-module byte_fifo, parameterised by FIFO_AW, twice: once for TX and once for RX.

Verification
REQ-032 SHALL cover: write sel0 0x41, 0x42 with tx_ready=1 -> tx stream emits 0x41 then 0x42, and tx_valid falls after that.
REQ-033 SHALL cover: tx_ready=0, 17 writes to sel0 -> 16 bytes stored, 17th dropped, and sel1 read returns 0x02.
REQ-034 SHALL cover: rx pushes 0x55; read sel0 -> io_dout=0x55 next cycle; read sel0 again -> 0x00.
REQ-035 SHALL cover: write sel4 0x07 -> halt=1 and exit_code=0x07; write sel4 0x09 -> exit_code remains 0x07.
REQ-036 SHALL cover: rdy_in=0 with io_en=1 and write sel0 -> TX FIFO unchanged; then rst_in mid-stream -> tx_valid=0 and rx_ready=1.
REQ-037 SHALL cover, with MMIO_CYCLE_COUNTER_EN defined: reset, 100 idle cycles, write sel7 -> reads of sel4..7 give 0x64(±pipeline constant),00,00,00.
